// File: rtl/vga_timing_gen.sv
// Pixel/line timing generator with registered sync/video outputs and a PIR-driven hold timer
// that selects a per-frame colour. Define VGA_TEST_PATTERN_EN to add the 8-bar test pattern.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE    = 1920,
  parameter int unsigned H_FP         = 88,
  parameter int unsigned H_SYNC       = 44,
  parameter int unsigned H_BP         = 148,
  parameter int unsigned V_VISIBLE    = 1080,
  parameter int unsigned V_FP         = 4,
  parameter int unsigned V_SYNC       = 5,
  parameter int unsigned V_BP         = 36,
  parameter logic        HS_POL       = 1'b1,
  parameter logic        VS_POL       = 1'b1,
  parameter int unsigned HOLD_CYCLES  = 444000000,
  parameter logic [11:0] COLOR_MOTION = 12'h0F0,
  parameter logic [11:0] COLOR_IDLE   = 12'h00F
) (
  input  logic        clk_148Mhz,
  input  logic        reset,
  input  logic        pir_signal,
  input  logic        pattern_sel,
  output logic        h_sync,
  output logic        v_sync,
  output logic        video_on,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        led
);
  localparam logic [11:0] H_TOTAL  = 12'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOTAL  = 12'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FP + V_SYNC);
  // The timer is 28 bits wide; a larger hold request saturates at the longest representable hold.
  localparam logic [27:0] HOLD_LOAD = (HOLD_CYCLES > 32'h0FFF_FFFF) ? 28'hFFF_FFFF : 28'(HOLD_CYCLES);

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        sync1_q, sync1_d, pir_s_q, pir_s_d;
  logic [27:0] timer_q, timer_d;
  logic        led_q, led_d, disp_motion_q, disp_motion_d;
  logic        h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic        video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        line_end, frame_end, visible;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'((H_VISIBLE / 8 == 0) ? 1 : H_VISIBLE / 8);
  logic [11:0] bar_raw;
  logic [2:0]  bar_idx;
`else
  logic pattern_sel_unused;
  assign pattern_sel_unused = pattern_sel;
`endif

  always_comb begin
    line_end  = (h_cnt_q == H_TOTAL - 12'd1);
    frame_end = line_end && (v_cnt_q == V_TOTAL - 12'd1);
    visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    h_cnt_d = line_end ? '0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (line_end) v_cnt_d = (v_cnt_q == V_TOTAL - 12'd1) ? '0 : v_cnt_q + 12'd1;

    sync1_d = pir_signal;
    pir_s_d = sync1_q;

    // A fresh detection always reloads, so a retrigger at timer==1 never lets it reach zero.
    timer_d = timer_q;
    if (pir_s_q)              timer_d = HOLD_LOAD;
    else if (timer_q != '0)   timer_d = timer_q - 28'd1;

    led_d         = (timer_q != '0);
    disp_motion_d = frame_end ? (timer_q != '0) : disp_motion_q;

    h_sync_d      = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    v_sync_d      = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    video_on_d    = visible;
    pix_x_d       = h_cnt_q;
    pix_y_d       = v_cnt_q;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    rgb_d = '0;
    if (visible) rgb_d = disp_motion_q ? COLOR_MOTION : COLOR_IDLE;
`ifdef VGA_TEST_PATTERN_EN
    bar_raw = h_cnt_q / BAR_W;
    bar_idx = (bar_raw > 12'd7) ? 3'd7 : bar_raw[2:0];
    if (visible && pattern_sel) rgb_d = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
`endif
  end

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sync1_q       <= 1'b0;
      pir_s_q       <= 1'b0;
      timer_q       <= '0;
      led_q         <= 1'b0;
      disp_motion_q <= 1'b0;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      video_on_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sync1_q       <= sync1_d;
      pir_s_q       <= pir_s_d;
      timer_q       <= timer_d;
      led_q         <= led_d;
      disp_motion_q <= disp_motion_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign video_on    = video_on_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign led         = led_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with reduced timing (24x8 totals, hold of 50 clocks);
// expected outputs are queued against the clock-edge index and checked on the falling edge.
module tb_vga_timing_gen;
  localparam int unsigned HT = 24;
  localparam int unsigned VT = 8;
`ifdef VGA_TEST_PATTERN_EN
  localparam logic PAT_BUILT = 1'b1;
`else
  localparam logic PAT_BUILT = 1'b0;
`endif

  logic clk_148Mhz = 1'b0;
  logic reset = 1'b1;
  logic pir_signal = 1'b0;
  logic pattern_sel = 1'b0;

  logic hs_p, vs_p, von_p, fs_p, led_p;
  logic [11:0] px_p, py_p;
  logic [3:0] r_p, g_p, b_p;
  logic hs_n, vs_n, von_n, fs_n, led_n;
  logic [11:0] px_n, py_n;
  logic [3:0] r_n, g_n, b_n;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .HOLD_CYCLES(50)
  ) dut_p (
    .clk_148Mhz(clk_148Mhz), .reset(reset), .pir_signal(pir_signal), .pattern_sel(pattern_sel),
    .h_sync(hs_p), .v_sync(vs_p), .video_on(von_p), .pix_x(px_p), .pix_y(py_p),
    .frame_start(fs_p), .red(r_p), .green(g_p), .blue(b_p), .led(led_p)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .HOLD_CYCLES(50)
  ) dut_n (
    .clk_148Mhz(clk_148Mhz), .reset(reset), .pir_signal(pir_signal), .pattern_sel(pattern_sel),
    .h_sync(hs_n), .v_sync(vs_n), .video_on(von_n), .pix_x(px_n), .pix_y(py_n),
    .frame_start(fs_n), .red(r_n), .green(g_n), .blue(b_n), .led(led_n)
  );

  always #5 clk_148Mhz = ~clk_148Mhz;

  typedef struct {
    int unsigned epoch;
    int unsigned at_n;
    int unsigned kind;
    logic [11:0] val;
  } exp_t;

  exp_t sb_q[$];
  int unsigned epoch = 1;
  int unsigned n_edges = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  exp_t cur;
  logic [11:0] got;

  // Rising edges seen since reset was last released; outputs after edge n show counter state n-1.
  always @(posedge clk_148Mhz or posedge reset)
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;

  function automatic logic [11:0] field(int unsigned kind);
    case (kind)
      0:       field = {11'd0, hs_p};
      1:       field = {11'd0, vs_p};
      2:       field = {11'd0, von_p};
      3:       field = px_p;
      4:       field = py_p;
      5:       field = {11'd0, fs_p};
      6:       field = {r_p, g_p, b_p};
      7:       field = {11'd0, led_p};
      8:       field = {11'd0, hs_n};
      default: field = {11'd0, vs_n};
    endcase
  endfunction

  function automatic string kname(int unsigned kind);
    case (kind)
      0:       kname = "h_sync";
      1:       kname = "v_sync";
      2:       kname = "video_on";
      3:       kname = "pix_x";
      4:       kname = "pix_y";
      5:       kname = "frame_start";
      6:       kname = "rgb";
      7:       kname = "led";
      8:       kname = "h_sync_neg";
      default: kname = "v_sync_neg";
    endcase
  endfunction

  function automatic void push(int unsigned at_n, int unsigned kind, logic [11:0] val);
    exp_t e;
    e.epoch = epoch;
    e.at_n  = at_n;
    e.kind  = kind;
    e.val   = val;
    sb_q.push_back(e);
  endfunction

  function automatic logic [11:0] exp_rgb(int unsigned n, logic disp, logic pat);
    int unsigned s, h, v, bi;
    logic [2:0] b;
    s = n - 1;
    h = s % HT;
    v = (s / HT) % VT;
    if (!(h < 16 && v < 4)) return 12'h000;
    if (pat) begin
      bi = (h / 2 > 7) ? 7 : h / 2;
      b  = 3'(bi);
      return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    end
    return disp ? 12'h0F0 : 12'h00F;
  endfunction

  // Monitor: entries whose slot has passed are reported as missed, then due entries are compared.
  always @(negedge clk_148Mhz) begin
    while (sb_q.size() > 0 &&
           (sb_q[0].epoch < epoch || (sb_q[0].epoch == epoch && sb_q[0].at_n < n_edges))) begin
      cur = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_%s epoch=%0d n=%0d got=none want=%h", kname(cur.kind), cur.epoch, cur.at_n, cur.val);
    end
    while (sb_q.size() > 0 && sb_q[0].epoch == epoch && sb_q[0].at_n == n_edges) begin
      cur = sb_q.pop_front();
      got = field(cur.kind);
      total++;
      if (got !== cur.val) begin
        bad++;
        $display("FAIL %s epoch=%0d n=%0d got=%h want=%h", kname(cur.kind), cur.epoch, cur.at_n, got, cur.val);
      end
    end
  end

  task automatic wait_edge(int unsigned m);
    while (n_edges < m) begin
      @(posedge clk_148Mhz);
      #2;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_148Mhz);
    #2;
    epoch++;
    reset = 1'b1;
    for (int unsigned k = 0; k < 8; k++) push(0, k, 12'h000);
    push(0, 8, 12'h001);
    push(0, 9, 12'h001);
    #1;
    total++;
    if (hs_p !== 1'b0 || vs_p !== 1'b0) begin
      bad++;
      $display("FAIL reset_sync_pos hs=%b vs=%b", hs_p, vs_p);
    end
    total++;
    if (hs_n !== 1'b1 || vs_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_sync_neg hs=%b vs=%b", hs_n, vs_n);
    end
    total++;
    if (fs_p !== 1'b0 || led_p !== 1'b0 || von_p !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl fs=%b led=%b von=%b", fs_p, led_p, von_p);
    end
    total++;
    if ({r_p, g_p, b_p} !== 12'h000 || px_p !== 12'h000 || py_p !== 12'h000) begin
      bad++;
      $display("FAIL reset_data rgb=%h x=%h y=%h", {r_p, g_p, b_p}, px_p, py_p);
    end
    repeat (2) @(posedge clk_148Mhz);
    #2;
    reset = 1'b0;
  endtask

  task automatic pulse_pir(int unsigned p);
    wait_edge(p);
    pir_signal = 1'b1;
    wait_edge(p + 1);
    pir_signal = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h, v;
    logic hs, vs, vid;

    // Free run: full timing on both polarities, idle colour, led low.
    do_reset();
    for (int unsigned n = 1; n <= 400; n++) begin
      h = (n - 1) % HT;
      v = ((n - 1) / HT) % VT;
      hs  = (h >= 18 && h < 21);
      vs  = (v == 5);
      vid = (h < 16 && v < 4);
      push(n, 0, {11'd0, hs});
      push(n, 1, {11'd0, vs});
      push(n, 2, {11'd0, vid});
      push(n, 3, 12'(h));
      push(n, 4, 12'(v));
      push(n, 5, {11'd0, (h == 0 && v == 0)});
      push(n, 6, exp_rgb(n, 1'b0, 1'b0));
      push(n, 7, 12'h000);
      push(n, 8, {11'd0, ~hs});
      push(n, 9, {11'd0, ~vs});
    end
    wait_edge(400);

    // Single PIR pulse late in frame 1: led 174..223, green only for frame 2.
    do_reset();
    for (int unsigned n = 1; n <= 400; n++) begin
      push(n, 5, {11'd0, ((n - 1) % 192 == 0)});
      push(n, 6, exp_rgb(n, (n >= 193 && n <= 384), 1'b0));
      push(n, 7, {11'd0, (n >= 174 && n <= 223)});
    end
    pulse_pir(170);
    wait_edge(400);

    // Retrigger landing exactly when timer==1: led 104..203 without a gap, frame 2 green.
    do_reset();
    for (int unsigned n = 1; n <= 400; n++) begin
      push(n, 6, exp_rgb(n, (n >= 193 && n <= 384), 1'b0));
      push(n, 7, {11'd0, (n >= 104 && n <= 203)});
    end
    pulse_pir(100);
    pulse_pir(150);
    wait_edge(400);

    // Reset in the cycle where h_cnt=10, v_cnt=2 while the timer is running.
    do_reset();
    for (int unsigned n = 1; n <= 57; n++) begin
      push(n, 3, 12'((n - 1) % HT));
      push(n, 4, 12'(((n - 1) / HT) % VT));
      push(n, 7, {11'd0, (n >= 24)});
    end
    pulse_pir(20);
    wait_edge(57);
    do_reset();
    for (int unsigned n = 1; n <= 30; n++) begin
      push(n, 3, 12'((n - 1) % HT));
      push(n, 4, 12'(((n - 1) / HT) % VT));
      push(n, 5, {11'd0, (n == 1)});
      push(n, 6, exp_rgb(n, 1'b0, 1'b0));
      push(n, 7, 12'h000);
    end
    wait_edge(30);

    // Test-pattern request over line 0 and its blanking.
    do_reset();
    pattern_sel = 1'b1;
    for (int unsigned n = 1; n <= 24; n++) push(n, 6, exp_rgb(n, 1'b0, PAT_BUILT));
    wait_edge(24);
    pattern_sel = 1'b0;

    // Retire the epoch so anything left unchecked is reported as missed.
    @(posedge clk_148Mhz);
    #2;
    epoch++;
    repeat (3) @(negedge clk_148Mhz);
    #1;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard not drained: %0d left", sb_q.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL too few checks: %0d", total);
    end
    if (bad == 0) $display("PASS");
    else          $display("FAIL bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
